uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serialises bytes into UART frames for the sensor's debug/readout link.
- Sits directly upstream of the receiver: its `tx` output drives the receiver's serial input on-chip in loopback and off-chip through a pad.
- Frame format is fixed to match the receiver:
  - start bit 0;
  - 8 data bits, MSB first;
  - STOP_BITS stop bits at 1.
- Bytes arrive on a valid/ready handshake and pass through a one-entry holding register. This lets the next byte queue up while the current frame shifts out.

Parameters:
- CLKS_PER_BIT, default 1. Clock cycles per serial bit; legal range 1..65535. The default of 1 matches the receiver's one-sample-per-clock timing.
- STOP_BITS, default 2. Stop bits per frame; legal range 1..4. The minimum of 2 at CLKS_PER_BIT=1 covers the receiver's STOP→IDLE turnaround before the next start bit.

Ports:
- clk  input  1  System clock; all flops are rising-edge.
- rst  input  1  Asynchronous, active-high reset.
- in_valid  input  1  Byte offered on in_data.
- in_data  input  8  Byte to transmit.
- in_ready  output  1  Holding register empty. Driven directly from a flop; no combinational path from in_valid.
- tx  output  1  Serial line, registered; idles high.
- busy  output  1  High while a frame is shifting (state ≠ IDLE) or the holding register is full.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- Values while rst is high:
  - tx=1, in_ready=1, busy=0;
  - holding register empty; FSM in IDLE;
  - all counters 0.
- Reset mid-frame: tx returns to 1 immediately (asynchronously) and the partial frame and any held byte are discarded. After rst is released, no frame starts until a new transfer occurs.
- Transfer: happens at an edge where in_valid && in_ready. in_data is captured into hold and hold_full sets.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If hold_full, on the next edge: load the shifter from hold, clear hold_full, enter START, drive tx<=0.
  - Latency: a transfer at edge E0 gives tx falling at edge E1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with tx=shifter[7].
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles; the shifter shifts left.
  - A 3-bit counter runs 0..7; after bit 7 completes, enter STOP with tx=1.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. At the final cycle's edge:
  - if hold_full: go directly to START, loading hold (gap-free back-to-back);
  - else: go to IDLE.
- Simultaneous events:
  - A transfer on the same edge that hold empties into the shifter: the new byte is accepted and hold_full stays 1.
  - in_ready is low only while hold is full.
- Baud counter:
  - width max(1, $clog2(CLKS_PER_BIT));
  - counts 0..CLKS_PER_BIT-1;
  - resets to 0 on every state change;
  - at CLKS_PER_BIT=1 it is constant 0 and each bit lasts exactly one cycle.
- Frame length: (1 + 8 + STOP_BITS)×CLKS_PER_BIT cycles; 11 cycles at the defaults.
- in_data is don't-care when in_valid=0. in_valid may drop without a transfer (no protocol error).

Decomposition:
- Package uart_pkg, shared with the receiver, holds:
  - typedef uart_tx_state_t {IDLE, START, DATA, STOP};
  - UART_DATA_W=8;
  - START_LVL=1'b0 and IDLE_LVL=1'b1.
- One sub-module: uart_baud_cnt, parameterised by CLKS_PER_BIT.
  - Input: clear.
  - Output: bit_done, high in the last cycle of a bit period.
  - Reused later by a receiver that oversamples.

Test Plan:
- Single byte, CLKS_PER_BIT=1, STOP_BITS=2: send 0xA5 at edge E0. Required tx from E1, one bit per cycle: 0,1,0,1,0,0,1,0,1,1,1, then idle 1. busy is high from E0+1 until the frame ends.
- Loopback into the receiver: send 0xA5, then 0x3C. The receiver must pulse out_valid with data_out 0xA5, then 0x3C, with no spurious frames.
- Back-to-back: hold in_valid high with 0x3C then 0xC3.
  - Second transfer is accepted while the first frame is shifting; in_ready stays low until hold empties.
  - Second start bit follows the last stop bit with zero idle cycles.
- Backpressure: keep in_valid=1 and change in_data only after a transfer. No byte is lost or duplicated over 16 random bytes checked at the receiver.
- CLKS_PER_BIT=4, STOP_BITS=1, byte 0x81: each bit lasts exactly 4 cycles; total frame is 40 cycles; tx pattern is 0,1,0,0,0,0,0,0,1,1 per bit period.
- Reset mid-frame: assert rst during bit 3 of 0xFF with hold full.
  - Required: tx=1, in_ready=1, busy=0 immediately.
  - After release, tx stays 1 for 20 cycles with in_valid=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_tx_state_t : transmitter FSM states
//   UART_DATA_W     : payload bits per frame
//   START_LVL       : line level of the start bit
//   IDLE_LVL        : line level when idle and during stop bits
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

   localparam int   UART_DATA_W = 8;
   localparam logic START_LVL   = 1'b0;
   localparam logic IDLE_LVL    = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period timer for the UART.
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   clear    in  restart the bit period at 0 on the next edge
//   bit_done out high during the last clock of a bit period
// The counter counts 0..CLKS_PER_BIT-1 and wraps by itself, so consecutive
// bits in the same state need no clear.  At CLKS_PER_BIT=1 it stays at 0 and
// bit_done is permanently high.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_done
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_r;

   assign bit_done = (cnt_r == LAST);

   // Bit-period counter: restart on clear or at the end of each period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clear || bit_done) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-to-UART-frame serialiser with a one-entry holding register.
// Frame: start bit 0, 8 data bits MSB first, STOP_BITS stop bits at 1.
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   in_valid in   byte offered on in_data
//   in_data  in   byte to transmit
//   in_ready out  holding register empty (registered)
//   tx       out  serial line (registered, idles high)
//   busy     out  frame in flight or holding register full (registered)
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [UART_DATA_W-1:0] in_data,
   output logic                   in_ready,
   output logic                   tx,
   output logic                   busy
);

   localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

   uart_tx_state_t         state_r, state_next_s;
   logic [UART_DATA_W-1:0] hold_r, shift_r;
   logic                   hold_full_r, hold_full_next_s;
   logic                   in_ready_r, busy_r, tx_r, tx_next_s;
   logic [2:0]             bit_idx_r, bit_idx_next_s;
   logic [1:0]             stop_cnt_r, stop_cnt_next_s;
   logic                   load_s, shift_s, xfer_s, bit_done_s, clear_s;

   assign in_ready = in_ready_r;
   assign tx       = tx_r;
   assign busy     = busy_r;

   assign xfer_s  = in_valid && in_ready_r;
   // Every state change restarts the bit period.
   assign clear_s = (state_next_s != state_r);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_s),
      .bit_done (bit_done_s)
   );

   // Next-state, next-tx and shifter control for the frame sequencer.
   always_comb begin
      state_next_s    = state_r;
      tx_next_s       = tx_r;
      load_s          = 1'b0;
      shift_s         = 1'b0;
      bit_idx_next_s  = bit_idx_r;
      stop_cnt_next_s = stop_cnt_r;
      case (state_r)
         IDLE: begin
            if (hold_full_r) begin
               load_s       = 1'b1;
               state_next_s = START;
               tx_next_s    = START_LVL;
            end else begin
               tx_next_s    = IDLE_LVL;
            end
         end
         START: begin
            if (bit_done_s) begin
               state_next_s   = DATA;
               tx_next_s      = shift_r[UART_DATA_W-1];
               bit_idx_next_s = 3'd0;
            end else begin
               tx_next_s      = START_LVL;
            end
         end
         DATA: begin
            if (bit_done_s && (bit_idx_r == 3'd7)) begin
               state_next_s    = STOP;
               tx_next_s       = IDLE_LVL;
               stop_cnt_next_s = 2'd0;
            end else if (bit_done_s) begin
               // The next MSB is shifter[6] before this edge's shift.
               shift_s        = 1'b1;
               tx_next_s      = shift_r[UART_DATA_W-2];
               bit_idx_next_s = bit_idx_r + 3'd1;
            end else begin
               tx_next_s      = tx_r;
            end
         end
         STOP: begin
            if (bit_done_s && (stop_cnt_r == STOP_LAST)) begin
               if (hold_full_r) begin
                  // Gap-free back-to-back frame.
                  load_s       = 1'b1;
                  state_next_s = START;
                  tx_next_s    = START_LVL;
               end else begin
                  state_next_s = IDLE;
                  tx_next_s    = IDLE_LVL;
               end
            end else if (bit_done_s) begin
               stop_cnt_next_s = stop_cnt_r + 2'd1;
               tx_next_s       = IDLE_LVL;
            end else begin
               tx_next_s       = IDLE_LVL;
            end
         end
         default: begin
            state_next_s = IDLE;
            tx_next_s    = IDLE_LVL;
         end
      endcase
   end

   // Holding-register occupancy: a new transfer wins over the load that empties it.
   always_comb begin
      if (xfer_s) begin
         hold_full_next_s = 1'b1;
      end else if (load_s) begin
         hold_full_next_s = 1'b0;
      end else begin
         hold_full_next_s = hold_full_r;
      end
   end

   // State, counters, shifter, holding register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         tx_r        <= IDLE_LVL;
         hold_r      <= '0;
         hold_full_r <= 1'b0;
         shift_r     <= '0;
         bit_idx_r   <= 3'd0;
         stop_cnt_r  <= 2'd0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         tx_r        <= tx_next_s;
         hold_full_r <= hold_full_next_s;
         bit_idx_r   <= bit_idx_next_s;
         stop_cnt_r  <= stop_cnt_next_s;
         in_ready_r  <= ~hold_full_next_s;
         busy_r      <= (state_next_s != IDLE) || hold_full_next_s;
         if (xfer_s) begin
            hold_r <= in_data;
         end else begin
            hold_r <= hold_r;
         end
         if (load_s) begin
            shift_r <= hold_r;
         end else if (shift_s) begin
            shift_r <= {shift_r[UART_DATA_W-2:0], 1'b0};
         end else begin
            shift_r <= shift_r;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// dut_a runs the default timing (1 clock/bit, 2 stop bits); dut_b runs
// 4 clocks/bit with 1 stop bit.  Expected line activity comes from a frame
// model (bit k of a frame) and a behavioural receiver that decodes a captured
// tx trace back into bytes.
module tb_uart_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       in_valid_a, in_ready_a, tx_a, busy_a;
   logic [7:0] in_data_a;
   logic       in_valid_b, in_ready_b, tx_b, busy_b;
   logic [7:0] in_data_b;

   uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a),
      .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a));

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
      .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b));

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic       cap[$];
   logic       bcap[$];
   logic [7:0] sent_q[$];
   logic [7:0] got_q[$];
   int         frame_errs;

   // Line level of bit k of a frame carrying b (k=0 start, 1..8 data MSB first, then 1).
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      else if (k <= 8) return b[8-k];
      else return 1'b1;
   endfunction

   // Behavioural receiver for 1 clock/bit, 2 stop bits: decode cap into got_q.
   task automatic decode_capture();
      int i;
      logic [7:0] b;
      got_q.delete();
      frame_errs = 0;
      i = 0;
      while (i < cap.size()) begin
         if (cap[i] === 1'b0 && (i + 10) < cap.size()) begin
            b = 8'h00;
            for (int j = 1; j <= 8; j++) b = {b[6:0], cap[i+j]};
            got_q.push_back(b);
            if (cap[i+9] !== 1'b1 || cap[i+10] !== 1'b1) frame_errs++;
            i += 11;
         end else begin
            i++;
         end
      end
   endtask

   // Stream sent_q into dut_a, changing in_data only after a transfer; capture tx.
   task automatic run_stream(input bit gaps, input int budget);
      int   idx;
      logic ready_prev;
      idx = 0;
      cap.delete();
      @(negedge clk);
      for (int c = 0; c < budget; c++) begin
         if (idx < sent_q.size()) begin
            in_data_a  = sent_q[idx];
            in_valid_a = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         end else begin
            in_valid_a = 1'b0;
         end
         ready_prev = in_ready_a;
         @(negedge clk);
         if (in_valid_a && ready_prev) idx++;
         cap.push_back(tx_a);
      end
      in_valid_a = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid_a = 1'b0; in_data_a = 8'h00;
      in_valid_b = 1'b0; in_data_b = 8'h00;
      repeat (3) @(negedge clk);
      tests_run++; if (tx_a !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_a: got %b expected 1", tx_a); end
      tests_run++; if (in_ready_a !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_a: got %b expected 1", in_ready_a); end
      tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
      tests_run++; if (tx_b !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_b: got %b expected 1", tx_b); end
      tests_run++; if (in_ready_b !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_b: got %b expected 1", in_ready_b); end
      tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      int   bad;
      logic busy_ok;
      @(negedge clk);
      in_valid_a = 1'b1; in_data_a = 8'hA5;
      @(negedge clk);                      // transfer at E0
      in_valid_a = 1'b0;
      tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL single_busy_start: got %b expected 1", busy_a); end
      tests_run++; if (tx_a !== 1'b1) begin tests_failed++; $display("FAIL single_tx_before_e1: got %b expected 1", tx_a); end
      cap.delete();
      busy_ok = 1'b1;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         cap.push_back(tx_a);
         if (busy_a !== 1'b1) busy_ok = 1'b0;
      end
      tests_run++; if (busy_ok !== 1'b1) begin tests_failed++; $display("FAIL single_busy_frame: got 0 during frame expected 1"); end
      @(negedge clk);
      cap.push_back(tx_a);
      tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end: got %b expected 0", busy_a); end
      repeat (3) begin @(negedge clk); cap.push_back(tx_a); end
      bad = 0;
      for (int k = 0; k < cap.size(); k++)
         if (cap[k] !== frame_bit(8'hA5, k)) begin
            if (bad == 0) $display("FAIL single_stream: bit %0d got %b expected %b", k, cap[k], frame_bit(8'hA5, k));
            bad++;
         end
      tests_run++; if (bad != 0) tests_failed++;
   endtask

   task automatic test_back_to_back();
      int   bad, low_cnt;
      logic exp_b;
      repeat (5) @(negedge clk);
      in_valid_a = 1'b1; in_data_a = 8'h3C;
      @(negedge clk);                      // after E0: 0x3C held
      in_data_a = 8'hC3;
      tests_run++; if (in_ready_a !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_full: got %b expected 0", in_ready_a); end
      cap.delete();
      @(negedge clk);                      // after E1: hold moved to shifter
      cap.push_back(tx_a);
      tests_run++; if (in_ready_a !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_empty: got %b expected 1", in_ready_a); end
      @(negedge clk);                      // after E2: 0xC3 accepted mid-frame
      in_valid_a = 1'b0;
      cap.push_back(tx_a);
      low_cnt = (in_ready_a === 1'b0) ? 1 : 0;
      for (int c = 3; c <= 32; c++) begin
         @(negedge clk);
         cap.push_back(tx_a);
         if (in_ready_a === 1'b0) low_cnt++;
      end
      tests_run++; if (low_cnt != 10) begin tests_failed++; $display("FAIL b2b_ready_low_cycles: got %0d expected 10", low_cnt); end
      bad = 0;
      for (int k = 0; k < cap.size(); k++) begin
         exp_b = (k < 11) ? frame_bit(8'h3C, k) : frame_bit(8'hC3, k - 11);
         if (cap[k] !== exp_b) begin
            if (bad == 0) $display("FAIL b2b_stream: bit %0d got %b expected %b", k, cap[k], exp_b);
            bad++;
         end
      end
      tests_run++; if (bad != 0) tests_failed++;
   endtask

   task automatic test_cpb4();
      int   bad;
      logic exp_b;
      @(negedge clk);
      in_valid_b = 1'b1; in_data_b = 8'h81;
      @(negedge clk);                      // transfer at E0
      in_valid_b = 1'b0;
      cap.delete(); bcap.delete();
      for (int c = 1; c <= 44; c++) begin
         @(negedge clk);
         cap.push_back(tx_b);
         bcap.push_back(busy_b);
      end
      bad = 0;
      for (int i = 0; i < cap.size(); i++) begin
         exp_b = (i < 40) ? frame_bit(8'h81, i / 4) : 1'b1;
         if (cap[i] !== exp_b) begin
            if (bad == 0) $display("FAIL cpb4_stream: cycle %0d got %b expected %b", i, cap[i], exp_b);
            bad++;
         end
      end
      tests_run++; if (bad != 0) tests_failed++;
      tests_run++; if (bcap[39] !== 1'b1) begin tests_failed++; $display("FAIL cpb4_busy_last: got %b expected 1", bcap[39]); end
      tests_run++; if (bcap[40] !== 1'b0) begin tests_failed++; $display("FAIL cpb4_busy_after: got %b expected 0", bcap[40]); end
   endtask

   task automatic check_received(input string name);
      logic [7:0] g;
      tests_run++;
      if (got_q.size() != sent_q.size()) begin
         tests_failed++;
         $display("FAIL %s_count: got %0d frames expected %0d", name, got_q.size(), sent_q.size());
      end
      tests_run++;
      if (frame_errs != 0) begin
         tests_failed++;
         $display("FAIL %s_framing: got %0d bad stop bits expected 0", name, frame_errs);
      end
      for (int i = 0; i < sent_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         tests_run++;
         if (g !== sent_q[i]) begin
            tests_failed++;
            $display("FAIL %s_byte%0d: got %h expected %h", name, i, g, sent_q[i]);
         end
      end
   endtask

   task automatic test_loopback();
      repeat (5) @(negedge clk);
      sent_q.delete();
      sent_q.push_back(8'hA5);
      sent_q.push_back(8'h3C);
      run_stream(1'b0, 40);
      decode_capture();
      check_received("loopback");
   endtask

   task automatic test_backpressure();
      repeat (5) @(negedge clk);
      sent_q.delete();
      for (int i = 0; i < 16; i++) sent_q.push_back(8'($urandom));
      run_stream(1'b0, 16 * 11 + 30);
      decode_capture();
      check_received("backpressure");
   endtask

   task automatic test_random_gaps();
      repeat (5) @(negedge clk);
      sent_q.delete();
      for (int i = 0; i < 16; i++) sent_q.push_back(8'($urandom));
      run_stream(1'b1, 16 * 11 * 2 + 60);
      decode_capture();
      check_received("random_gaps");
   endtask

   task automatic test_reset_mid();
      int bad;
      repeat (5) @(negedge clk);
      in_valid_a = 1'b1; in_data_a = 8'hFF;
      @(negedge clk);                      // after E0: first 0xFF held
      @(negedge clk);                      // after E1: start bit, hold empty
      @(negedge clk);                      // after E2: second 0xFF held, data bit 0
      in_valid_a = 1'b0;
      repeat (3) @(negedge clk);           // after E5: data bit 3
      tests_run++; if (in_ready_a !== 1'b0) begin tests_failed++; $display("FAIL rstmid_hold_full: got %b expected 0", in_ready_a); end
      #2 rst = 1'b1;
      #1;
      tests_run++; if (tx_a !== 1'b1) begin tests_failed++; $display("FAIL rstmid_tx: got %b expected 1", tx_a); end
      tests_run++; if (in_ready_a !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 1", in_ready_a); end
      tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || in_ready_a !== 1'b1) bad++;
      end
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL rstmid_quiet_after: got %0d active cycles expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_cpb4();
      test_loopback();
      test_backpressure();
      test_random_gaps();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
